// File: rtl/rf_fifo_ctrl.sv
// FIFO controller in front of a single-port-address 1R/1W register file, with a one-entry output register.
// Optional macro RF_FIFO_BYPASS_EN: an empty FIFO loads incoming data straight into the output register.
module rf_fifo_ctrl #(
    parameter int unsigned Dwidth = 8,
    parameter int unsigned Awidth = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [Dwidth-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [Dwidth-1:0] out_data,
    output logic [Awidth-1:0] rf_addr,
    output logic              rf_wen,
    output logic [Dwidth-1:0] rf_din,
    input  logic [Dwidth-1:0] rf_dout,
    output logic [Awidth:0]   count
);
    localparam int unsigned DEPTH = 2 ** Awidth;
    localparam int unsigned CW    = Awidth + 1;

    typedef enum logic {PRI_READ, PRI_WRITE} pri_e;
    typedef enum logic [1:0] {G_IDLE, G_READ, G_WRITE, G_BYPASS} grant_e;

    logic [Awidth-1:0] wr_ptr, wr_ptr_nxt, rd_ptr, rd_ptr_nxt;
    logic [CW-1:0]     rf_cnt, rf_cnt_nxt;
    logic              out_valid_nxt;
    logic [Dwidth-1:0] out_data_nxt;
    pri_e              pri, pri_nxt;
    grant_e            grant;
    logic              rd_req, wr_req, byp_req, slot_free;

    assign slot_free = !out_valid || out_ready;
    assign rd_req    = (rf_cnt != '0) && slot_free;
    assign wr_req    = in_valid && (rf_cnt != CW'(DEPTH));
`ifdef RF_FIFO_BYPASS_EN
    assign byp_req   = in_valid && (rf_cnt == '0) && slot_free;
`else
    assign byp_req   = 1'b0;
`endif
    assign count     = rf_cnt + CW'(out_valid);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rf_cnt    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            pri       <= PRI_READ;
        end else begin
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            rf_cnt    <= rf_cnt_nxt;
            out_valid <= out_valid_nxt;
            out_data  <= out_data_nxt;
            pri       <= pri_nxt;
        end
    end

    // Arbitration of the shared address, register-file drive and next state
    always_comb begin
        grant         = G_IDLE;
        in_ready      = 1'b0;
        rf_wen        = 1'b0;
        rf_addr       = rd_ptr;
        rf_din        = in_data;
        wr_ptr_nxt    = wr_ptr;
        rd_ptr_nxt    = rd_ptr;
        rf_cnt_nxt    = rf_cnt;
        out_valid_nxt = out_valid;
        out_data_nxt  = out_data;
        pri_nxt       = pri;

        if (!rst) begin
            if (byp_req)              grant = G_BYPASS;
            else if (rd_req && wr_req) grant = (pri == PRI_READ) ? G_READ : G_WRITE;
            else if (rd_req)          grant = G_READ;
            else if (wr_req)          grant = G_WRITE;
        end

        if (out_valid && out_ready) out_valid_nxt = 1'b0;

        case (grant)
            G_READ: begin
                out_data_nxt  = rf_dout;
                out_valid_nxt = 1'b1;
                rd_ptr_nxt    = rd_ptr + Awidth'(1);
                rf_cnt_nxt    = rf_cnt - CW'(1);
                pri_nxt       = PRI_WRITE;
            end
            G_WRITE: begin
                in_ready   = 1'b1;
                rf_wen     = 1'b1;
                rf_addr    = wr_ptr;
                wr_ptr_nxt = wr_ptr + Awidth'(1);
                rf_cnt_nxt = rf_cnt + CW'(1);
                pri_nxt    = PRI_READ;
            end
            G_BYPASS: begin
                in_ready      = 1'b1;
                out_data_nxt  = in_data;
                out_valid_nxt = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_rf_fifo_ctrl.sv
// Self-checking bench for rf_fifo_ctrl: queue-based reference model plus a behavioural register file.
// Honours RF_FIFO_BYPASS_EN when the build defines it.
module tb_rf_fifo_ctrl;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 3;
    localparam int unsigned DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst, in_valid, in_ready, out_valid, out_ready, rf_wen;
    logic [DW-1:0] in_data, out_data, rf_din, rf_dout;
    logic [AW-1:0] rf_addr;
    logic [AW:0]   count;
    logic [DW-1:0] mem [DEPTH];

    int n_cmp = 0;
    int n_bad = 0;

    rf_fifo_ctrl #(.Dwidth(DW), .Awidth(AW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .rf_addr(rf_addr), .rf_wen(rf_wen), .rf_din(rf_din), .rf_dout(rf_dout),
        .count(count)
    );

    always #5 clk = ~clk;

    // Behavioural register file: write on clock, asynchronous read
    always @(posedge clk) if (rf_wen) mem[rf_addr] <= rf_din;
    assign rf_dout = mem[rf_addr];

    // Reference model state
    logic [DW-1:0] q[$];
    logic [DW-1:0] got[$];
    bit            m_ov = 1'b0;
    logic [DW-1:0] m_od = '0;
    bit            m_pref_write = 1'b0;
    int            n_wr = 0;
    int            n_rd = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check against model, advance model. Returns whether the item was taken.
    task automatic step(input bit r, input bit iv, input logic [DW-1:0] d, input bit ordy, output bit acc);
        bit can_take, rd, wr, byp;
        int op; // 0 idle, 1 read, 2 write, 3 bypass
        @(negedge clk);
        rst = r; in_valid = iv; in_data = d; out_ready = ordy;
        #1;
        can_take = !m_ov || ordy;
        rd  = (q.size() != 0) && can_take;
        wr  = iv && (q.size() != DEPTH);
`ifdef RF_FIFO_BYPASS_EN
        byp = iv && (q.size() == 0) && can_take;
`else
        byp = 1'b0;
`endif
        if (r)              op = 0;
        else if (byp)       op = 3;
        else if (rd && wr)  op = m_pref_write ? 2 : 1;
        else if (rd)        op = 1;
        else if (wr)        op = 2;
        else                op = 0;
        acc = (op == 2) || (op == 3);

        chk("in_ready", 32'(in_ready), 32'(acc));
        chk("rf_wen", 32'(rf_wen), 32'(op == 2));
        chk("rf_addr", 32'(rf_addr), (op == 2) ? 32'(n_wr % DEPTH) : 32'(n_rd % DEPTH));
        if (op == 2) chk("rf_din", 32'(rf_din), 32'(d));
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("out_data", 32'(out_data), 32'(m_od));
        chk("count", 32'(count), 32'(q.size() + int'(m_ov)));

        if (!r && out_valid && ordy) got.push_back(out_data);

        if (r) begin
            q.delete(); m_ov = 1'b0; m_od = '0; m_pref_write = 1'b0; n_wr = 0; n_rd = 0;
        end else begin
            if (m_ov && ordy) m_ov = 1'b0;
            case (op)
                1: begin m_od = q.pop_front(); m_ov = 1'b1; n_rd++; m_pref_write = 1'b1; end
                2: begin q.push_back(d); n_wr++; m_pref_write = 1'b0; end
                3: begin m_od = d; m_ov = 1'b1; end
                default: ;
            endcase
        end
    endtask

    initial begin
        bit acc;
        int idx;
        logic [DW-1:0] v;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // Reset held with upstream valid
        step(1, 1, 8'h55, 0, acc);
        step(1, 1, 8'h55, 0, acc);

        // Single item 0xA5
        got.delete();
        step(0, 1, 8'hA5, 1, acc);
        for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 1, acc);
        chk("single_n", 32'(got.size()), 32'd1);
        if (got.size() > 0) chk("single_val", 32'(got[0]), 32'hA5);

        // Fill with output stalled, then drain
        got.delete();
        idx = 1;
        for (int i = 0; i < 16; i++) begin
            v = DW'(idx);
            step(0, idx <= 10, v, 0, acc);
            if (acc) idx++;
        end
        step(0, 1, 8'h0A, 0, acc);
        chk("fill_count", 32'(count), 32'd9);
        chk("fill_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 30; i++) begin
            v = DW'(idx);
            step(0, idx <= 10, v, 1, acc);
            if (acc) idx++;
        end
        chk("drain_n", 32'(got.size()), 32'd10);
        for (int i = 0; i < got.size() && i < 10; i++) chk("drain_order", 32'(got[i]), 32'(i + 1));

        // Both sides continuously active
        got.delete();
        idx = 0;
        for (int i = 0; i < 50; i++) begin
            v = DW'(8'h10 + idx);
            step(0, idx < 16, v, 1, acc);
            if (acc) idx++;
        end
        chk("stream_n", 32'(got.size()), 32'd16);
        for (int i = 0; i < got.size() && i < 16; i++) chk("stream_order", 32'(got[i]), 32'(8'h10 + i));

        // Backpressure: output stalled while writes continue
        for (int i = 0; i < 12; i++) begin
            v = DW'($urandom);
            step(0, 1, v, 0, acc);
        end
        for (int i = 0; i < 20; i++) step(0, 0, 8'h00, 1, acc);

        // Mid-stream reset after 4 accepted and 1 consumed
        idx = 0;
        for (int i = 0; i < 10 && idx < 4; i++) begin
            v = DW'(8'h20 + idx);
            step(0, 1, v, 0, acc);
            if (acc) idx++;
        end
        step(0, 0, 8'h00, 1, acc);
        step(1, 1, 8'h77, 0, acc);
        step(0, 0, 8'h00, 0, acc);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ov", 32'(out_valid), 32'd0);
        got.delete();
        step(0, 1, 8'h3C, 1, acc);
        for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 1, acc);
        chk("after_rst_n", 32'(got.size()), 32'd1);
        if (got.size() > 0) chk("after_rst_val", 32'(got[0]), 32'h3C);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            v = DW'($urandom);
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), v,
                 ($urandom_range(0, 2) != 0), acc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
